capture_seq_arb: RTL and testbench

- Capture sequencer and access arbiter for the 96-bank ADC capture SRAM array.
- Runs an armed, circular pre-trigger capture followed by a programmable post-trigger count.
- After capture it grants host row reads, with logical-to-physical address unwrapping.
- Owns all bank cen/wen/addr/wdata; sits between the ADC sample bus, the host read port and the bank memory wrapper.

---
 rtl/capture_seq_arb.sv | 130 +++++++++++++
 tb/tb_capture_seq_arb.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_seq_arb.sv
// Capture sequencer and access arbiter for the banked ADC capture SRAM: circular
// pre-trigger capture, post-trigger count, then host row reads with address unwrap.
module capture_seq_arb #(
  parameter int NBANK = 96,
  parameter int DW    = 9,
  parameter int AW    = 15
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  trig,
  input  logic [AW-1:0]         post_len,
  input  logic                  adc_valid,
  input  logic [DW*NBANK-1:0]   adc_data,
  input  logic                  rd_req,
  input  logic [AW-1:0]         rd_addr,
  output logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DW*NBANK-1:0]   rd_data,
  output logic [NBANK-1:0]      mem_cen,
  output logic [NBANK-1:0]      mem_wen,
  output logic [AW*NBANK-1:0]   mem_addr,
  output logic [DW*NBANK-1:0]   mem_wdata,
  input  logic [DW*NBANK-1:0]   mem_rdata,
  output logic [1:0]            state,
  output logic [AW:0]           cap_len
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    POST = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [AW-1:0] ONE = AW'(1);

  state_t        st;
  logic [AW-1:0] waddr;
  logic [AW-1:0] post_cnt;
  logic [AW:0]   cap_len_q;
  logic          rd_s1;
  logic          rd_s2;
  logic          rd_acc;
  logic          wr_en;
  logic          capturing;
  logic [AW-1:0] start_row;
  logic [AW-1:0] rd_phys;

  // Read handshake: a read is accepted on any edge where rd_req and rd_ready are
  // both high; rd_valid then pulses for exactly one cycle two edges later.
  // rd_ready is low while capturing or while a read is in flight.
  assign rd_ready  = ((st == IDLE) || (st == DONE)) && !rd_s1 && !rd_s2;
  assign rd_acc    = rd_req && rd_ready;
  assign capturing = (st == PRE) || (st == POST);
  assign wr_en     = adc_valid && capturing && !arm && !abort;

  // Once the buffer has wrapped, the oldest row sits at the write pointer.
  assign start_row = cap_len_q[AW] ? waddr : '0;
  assign rd_phys   = start_row + rd_addr;

  assign state   = st;
  assign cap_len = cap_len_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st        <= IDLE;
      waddr     <= '0;
      post_cnt  <= '0;
      cap_len_q <= '0;
      rd_s1     <= 1'b0;
      rd_s2     <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      mem_cen   <= '1;
      mem_wen   <= '1;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_cen  <= '1;
      mem_wen  <= '1;
      rd_s1    <= rd_acc;
      rd_s2    <= rd_s1;
      rd_valid <= rd_s2;
      if (rd_s2) begin
        rd_data <= mem_rdata;
      end

      if (rd_acc) begin
        mem_cen  <= '0;
        mem_addr <= {NBANK{rd_phys}};
      end

      if (wr_en) begin
        mem_cen   <= '0;
        mem_wen   <= '0;
        mem_addr  <= {NBANK{waddr}};
        mem_wdata <= adc_data;
        waddr     <= waddr + ONE;
        if (!cap_len_q[AW]) begin
          cap_len_q <= cap_len_q + 1'b1;
        end
      end

      if (arm) begin
        st        <= PRE;
        waddr     <= '0;
        cap_len_q <= '0;
        post_cnt  <= (post_len == '0) ? ONE : post_len;
      end else if (abort) begin
        st <= IDLE;
      end else if (st == PRE && trig) begin
        // The sample written alongside the trigger is the first post sample.
        if (adc_valid) begin
          post_cnt <= post_cnt - ONE;
          st       <= (post_cnt == ONE) ? DONE : POST;
        end else begin
          st <= POST;
        end
      end else if (st == POST && adc_valid) begin
        post_cnt <= post_cnt - ONE;
        if (post_cnt == ONE) begin
          st <= DONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_capture_seq_arb.sv
// Directed bench for capture_seq_arb: SRAM stand-in, behavioural reference model
// with per-cycle compare, and hand-computed literal expectations.
module tb_capture_seq_arb;

  localparam int NBANK = 96;
  localparam int DW    = 9;
  localparam int AW    = 15;
  localparam int RW    = DW * NBANK;
  localparam int DEPTH = 1 << AW;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                arm = 1'b0;
  logic                abort = 1'b0;
  logic                trig = 1'b0;
  logic [AW-1:0]       post_len = '0;
  logic                adc_valid = 1'b0;
  logic [RW-1:0]       adc_data = '0;
  logic                rd_req = 1'b0;
  logic [AW-1:0]       rd_addr = '0;
  logic                rd_ready;
  logic                rd_valid;
  logic [RW-1:0]       rd_data;
  logic [NBANK-1:0]    mem_cen;
  logic [NBANK-1:0]    mem_wen;
  logic [AW*NBANK-1:0] mem_addr;
  logic [RW-1:0]       mem_wdata;
  logic [RW-1:0]       mem_rdata = '0;
  logic [1:0]          state;
  logic [AW:0]         cap_len;

  int n_chk = 0;
  int n_err = 0;

  capture_seq_arb #(.NBANK(NBANK), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rstn(rstn), .arm(arm), .abort(abort), .trig(trig),
    .post_len(post_len), .adc_valid(adc_valid), .adc_data(adc_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .mem_cen(mem_cen),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .state(state), .cap_len(cap_len)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- SRAM stand-in (registered read) ----------------
  logic [RW-1:0] sram [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) sram[i] = '0;
  end

  always @(posedge clk) begin
    for (int b = 0; b < NBANK; b++) begin
      if (!mem_cen[b]) begin
        if (!mem_wen[b]) sram[mem_addr[b*AW +: AW]][b*DW +: DW] <= mem_wdata[b*DW +: DW];
        else mem_rdata[b*DW +: DW] <= sram[mem_addr[b*AW +: AW]][b*DW +: DW];
      end
    end
  end

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] pat(input int k);
    logic [31:0] h;
    h = 32'(k) * 32'h9E37_79B1 + 32'h0123_4567;
    return {(RW/32){h}};
  endfunction

  // ---------------- behavioural model ----------------
  // States: 0 idle, 1 pre, 2 post, 3 done. Rows kept in an associative array.
  int            m_state = 0;
  int            m_waddr = 0;
  int            m_cap   = 0;
  int            m_post  = 0;
  int            m_lat   = 0;   // edges until the in-flight read returns
  int            m_issue = 0;   // 0 none, 1 write, 2 read during this cycle
  int            m_iaddr = 0;
  logic [RW-1:0] m_idata = '0;
  logic [RW-1:0] m_pend  = '0;
  logic          m_rv    = 1'b0;
  logic [RW-1:0] m_rdata = '0;
  logic [RW-1:0] m_mem [int];

  function automatic logic m_ready();
    return ((m_state == 0) || (m_state == 3)) && (m_lat == 0);
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_state = 0; m_waddr = 0; m_cap = 0; m_post = 0;
      m_lat = 0; m_issue = 0; m_rv = 1'b0;
    end else begin
      logic acc;
      logic in_post;
      int   phys;
      acc     = rd_req && m_ready();
      m_rv    = 1'b0;
      m_issue = 0;
      if (m_lat > 0) begin
        m_lat--;
        if (m_lat == 0) begin
          m_rv    = 1'b1;
          m_rdata = m_pend;
        end
      end
      if (acc) begin
        phys    = (((m_cap == DEPTH) ? m_waddr : 0) + int'(rd_addr)) % DEPTH;
        m_issue = 2;
        m_iaddr = phys;
        m_pend  = m_mem.exists(phys) ? m_mem[phys] : '0;
        m_lat   = 2;
      end
      if (arm) begin
        m_state = 1; m_waddr = 0; m_cap = 0;
        m_post  = (post_len == 0) ? 1 : int'(post_len);
      end else if (abort) begin
        m_state = 0;
      end else if (m_state == 1 || m_state == 2) begin
        in_post = (m_state == 2) || trig;
        if (m_state == 1 && trig) m_state = 2;
        if (adc_valid) begin
          m_issue = 1;
          m_iaddr = m_waddr;
          m_idata = adc_data;
          m_mem[m_waddr] = adc_data;
          m_waddr = (m_waddr + 1) % DEPTH;
          if (m_cap < DEPTH) m_cap++;
          if (in_post) begin
            m_post--;
            if (m_post == 0) m_state = 3;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int nbad;
    check("state", RW'(state), RW'(m_state));
    check("cap_len", RW'(cap_len), RW'(m_cap));
    check("rd_ready", RW'(rd_ready), RW'(m_ready()));
    check("mem_cen", RW'(mem_cen), (m_issue != 0) ? RW'(0) : RW'({NBANK{1'b1}}));
    check("mem_wen", RW'(mem_wen), (m_issue == 1) ? RW'(0) : RW'({NBANK{1'b1}}));
    if (m_issue != 0) begin
      nbad = 0;
      for (int b = 0; b < NBANK; b++)
        if (mem_addr[b*AW +: AW] != AW'(m_iaddr)) nbad++;
      check("mem_addr_bank0", RW'(mem_addr[AW-1:0]), RW'(m_iaddr));
      check("mem_addr_bad_banks", RW'(nbad), RW'(0));
    end
    if (m_issue == 1) check("mem_wdata", mem_wdata, m_idata);
    check("rd_valid", RW'(rd_valid), RW'(m_rv));
    if (m_rv) check("rd_data", rd_data, m_rdata);
  end

  // ---------------- driver tasks ----------------
  int wr_idx = 0;
  int base   = 0;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_arm(input int len);
    post_len = AW'(len);
    arm = 1'b1;
    step();
    arm = 1'b0;
    base = wr_idx;
  endtask

  task automatic write_rows(input int n, input logic with_trig);
    for (int i = 0; i < n; i++) begin
      adc_valid = 1'b1;
      trig      = with_trig && (i == 0);
      adc_data  = pat(wr_idx);
      wr_idx++;
      step();
    end
    adc_valid = 1'b0;
    trig      = 1'b0;
  endtask

  task automatic do_read(input int addr, output logic [RW-1:0] data);
    int k;
    k = 0;
    while (!rd_ready && k < 10) begin step(); k++; end
    if (!rd_ready) check("rd_ready_wait", RW'(rd_ready), RW'(1));
    rd_addr = AW'(addr);
    rd_req  = 1'b1;
    step();
    rd_req = 1'b0;
    k = 0;
    while (!rd_valid && k < 10) begin step(); k++; end
    if (!rd_valid) check("rd_valid_wait", RW'(rd_valid), RW'(1));
    data = rd_data;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [RW-1:0] d;
    int vcnt;
    int rcnt;

    step(); step();
    rstn = 1'b1;
    step();
    check("reset_state", RW'(state), RW'(0));
    check("reset_cap_len", RW'(cap_len), RW'(0));
    check("reset_rd_ready", RW'(rd_ready), RW'(1));
    check("reset_mem_cen", RW'(mem_cen), RW'({NBANK{1'b1}}));

    // Async reset in the middle of POST.
    do_arm(50);
    write_rows(4, 1'b0);
    write_rows(3, 1'b1);
    check("mid_post_state", RW'(state), RW'(2));
    rstn = 1'b0;
    #1;
    check("async_rst_state", RW'(state), RW'(0));
    check("async_rst_cap_len", RW'(cap_len), RW'(0));
    check("async_rst_mem_cen", RW'(mem_cen), RW'({NBANK{1'b1}}));
    check("async_rst_rd_valid", RW'(rd_valid), RW'(0));
    step();
    rstn = 1'b1;
    step();

    // 10 pre rows, trigger with a write, post_len=5 -> rows 0..14.
    do_arm(5);
    write_rows(10, 1'b0);
    check("pre_state", RW'(state), RW'(1));
    write_rows(5, 1'b1);
    check("short_done_state", RW'(state), RW'(3));
    check("short_cap_len", RW'(cap_len), RW'(15));
    write_rows(1, 1'b0);
    check("done_ignores_adc", RW'(cap_len), RW'(15));
    do_read(0, d);
    check("short_rd0", d, pat(base + 0));
    do_read(14, d);
    check("short_rd14", d, pat(base + 14));

    // Long capture that wraps the circular buffer.
    do_arm(100);
    write_rows(40000, 1'b0);
    write_rows(100, 1'b1);
    check("wrap_state", RW'(state), RW'(3));
    check("wrap_cap_len", RW'(cap_len), RW'(32768));
    do_read(0, d);
    check("wrap_oldest_row7332", d, pat(base + 7332));
    do_read(32767, d);
    check("wrap_newest_row7331", d, pat(base + 40099));

    // Back-to-back requests: one read per three cycles.
    while (!rd_ready) step();
    rd_addr = AW'(3);
    rd_req  = 1'b1;
    vcnt = 0;
    rcnt = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (rd_ready) rcnt++;
      if (rd_valid) begin
        vcnt++;
        check("b2b_rd_data", rd_data, pat(base + 7335));
      end
    end
    rd_req = 1'b0;
    check("b2b_valid_count", RW'(vcnt), RW'(3));
    check("b2b_ready_count", RW'(rcnt), RW'(3));
    step(); step(); step();

    // Read requests during capture are refused; abort returns to IDLE.
    do_arm(3);
    rd_req = 1'b1;
    rd_addr = '0;
    write_rows(3, 1'b0);
    check("pre_rd_ready", RW'(rd_ready), RW'(0));
    rd_req = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_state", RW'(state), RW'(0));
    check("abort_rd_ready", RW'(rd_ready), RW'(1));
    check("abort_cap_len_hold", RW'(cap_len), RW'(3));

    // post_len=0 behaves as 1: trigger write finishes the capture.
    do_arm(0);
    write_rows(2, 1'b0);
    write_rows(1, 1'b1);
    check("post0_state", RW'(state), RW'(3));
    check("post0_cap_len", RW'(cap_len), RW'(3));
    write_rows(1, 1'b0);
    check("post0_no_extra", RW'(cap_len), RW'(3));
    do_read(2, d);
    check("post0_rd2", d, pat(base + 2));

    step(); step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
